// File: rtl/mode_pkg.sv
// Shared types and constants for the mode arbiter.
// Holds the FSM state enum, one-hot mode codes and 7-segment digit codes.
package mode_pkg;

   typedef enum logic {
      MENU   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic [3:0] MODE1 = 4'b0001;
   localparam logic [3:0] MODE2 = 4'b0010;
   localparam logic [3:0] MODE3 = 4'b0100;
   localparam logic [3:0] MODE4 = 4'b1000;

   // Segment order a..g,dp from MSB, active-high
   localparam logic [7:0] NUM0  = 8'hFC;
   localparam logic [7:0] NUM1  = 8'h60;
   localparam logic [7:0] NUM2  = 8'hDA;
   localparam logic [7:0] NUM3  = 8'hF2;
   localparam logic [7:0] NUM4  = 8'h66;
   localparam logic [7:0] BLANK = 8'h00;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [7:0] mode_digit(input logic [3:0] m);
      logic [7:0] d;
      d = NUM1;
      unique case (1'b1)
         m[0]:    d = NUM1;
         m[1]:    d = NUM2;
         m[2]:    d = NUM3;
         m[3]:    d = NUM4;
         default: d = NUM1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-flop synchronizer, stability counter, edge pulse.
// Ports: clk, reset (sync, high), btn_raw (async in), btn_pulse (1-cycle out).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          prev_q, prev_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      prev_d  = level_q;
      pulse_d = level_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign btn_pulse = pulse_q;

endmodule

// File: rtl/mode_arbiter.sv
// Menu/mode arbiter: debounced buttons drive a MENU/ACTIVE FSM.
// Ports: clk, reset, confirm/select/exit (raw), sub_busy[3:0],
//        mode_sel[3:0], mode_entered, grant[3:0], menu_digit[7:0].
module mode_arbiter
   import mode_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       confirm,
   input  logic       select,
   input  logic       exit,
   input  logic [3:0] sub_busy,
   output logic [3:0] mode_sel,
   output logic       mode_entered,
   output logic [3:0] grant,
   output logic [7:0] menu_digit
);

   logic cfm_p, sel_p, ext_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cfm (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (confirm),
      .btn_pulse (cfm_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (select),
      .btn_pulse (sel_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (exit),
      .btn_pulse (ext_p)
   );

   state_t     state_q, state_d;
   logic [3:0] mode_sel_q, mode_sel_d;
   logic       entered_q, entered_d;
   logic [3:0] grant_q, grant_d;
   logic [7:0] digit_q, digit_d;

   always_comb begin
      state_d    = state_q;
      mode_sel_d = mode_sel_q;
      if (!is_onehot(mode_sel_q)) begin
         // Corrupted selection: recover to a known menu position
         state_d    = MENU;
         mode_sel_d = MODE1;
      end else begin
         unique case (state_q)
            MENU: begin
               if (cfm_p) begin
                  state_d = ACTIVE;
               end else if (sel_p) begin
                  mode_sel_d = {mode_sel_q[2:0], mode_sel_q[3]};
               end
            end
            ACTIVE: begin
               // Exit while owner is busy is dropped, not queued
               if (ext_p && ((sub_busy & mode_sel_q) == 4'b0000)) begin
                  state_d = MENU;
               end
            end
         endcase
      end
      // Outputs follow the next state so they move on the same edge
      entered_d = (state_d == ACTIVE);
      grant_d   = (state_d == ACTIVE) ? mode_sel_d : 4'b0000;
      digit_d   = (state_d == ACTIVE) ? BLANK : mode_digit(mode_sel_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= MENU;
         mode_sel_q <= MODE1;
         entered_q  <= 1'b0;
         grant_q    <= 4'b0000;
         digit_q    <= NUM1;
      end else begin
         state_q    <= state_d;
         mode_sel_q <= mode_sel_d;
         entered_q  <= entered_d;
         grant_q    <= grant_d;
         digit_q    <= digit_d;
      end
   end

   assign mode_sel     = mode_sel_q;
   assign mode_entered = entered_q;
   assign grant        = grant_q;
   assign menu_digit   = digit_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// Self-checking bench for mode_arbiter with DEBOUNCE_CYCLES=4.
// Run-length button model plus index-based FSM model, checked every cycle.
module tb_mode_arbiter;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       confirm = 1'b0;
   logic       select = 1'b0;
   logic       exit_b = 1'b0;
   logic [3:0] sub_busy = 4'b0000;
   logic [3:0] mode_sel;
   logic       mode_entered;
   logic [3:0] grant;
   logic [7:0] menu_digit;

   always #5 clk = ~clk;

   mode_arbiter #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk          (clk),
      .reset        (reset),
      .confirm      (confirm),
      .select       (select),
      .exit         (exit_b),
      .sub_busy     (sub_busy),
      .mode_sel     (mode_sel),
      .mode_entered (mode_entered),
      .grant        (grant),
      .menu_digit   (menu_digit)
   );

   int errs = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  cyc = 0;
   bit  m_act = 1'b0;
   int  m_idx = 0;
   bit  force_flag = 1'b0;
   bit  run_val [3];
   int  run_len [3];
   bit  mlev [3];
   int  due [3];
   logic [7:0] dig_tab [4];

   initial begin
      dig_tab[0] = 8'h60;
      dig_tab[1] = 8'hDA;
      dig_tab[2] = 8'hF2;
      dig_tab[3] = 8'h66;
      for (int i = 0; i < 3; i++) begin
         run_val[i] = 1'b0;
         run_len[i] = 1;
         mlev[i] = 1'b0;
         due[i] = -1;
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   task automatic model_step();
      bit r [3];
      bit p [3];
      r[0] = confirm;
      r[1] = select;
      r[2] = exit_b;
      for (int i = 0; i < 3; i++) p[i] = (due[i] == cyc);
      if (reset) begin
         m_act = 1'b0;
         m_idx = 0;
         for (int i = 0; i < 3; i++) begin
            run_val[i] = 1'b0;
            run_len[i] = 1;
            mlev[i] = 1'b0;
            due[i] = -1;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r[i] == run_val[i]) begin
               if (run_len[i] <= DC) run_len[i]++;
            end else begin
               run_val[i] = r[i];
               run_len[i] = 1;
            end
            // A run of DC equal samples is accepted; the press
            // reaches the FSM 4 edges after the last sample.
            if (run_len[i] == DC && run_val[i] != mlev[i]) begin
               mlev[i] = run_val[i];
               if (mlev[i]) due[i] = cyc + 4;
            end
         end
         if (force_flag) begin
            m_act = 1'b0;
            m_idx = 0;
            force_flag = 1'b0;
         end else if (!m_act) begin
            if (p[0]) m_act = 1'b1;
            else if (p[1]) m_idx = (m_idx + 1) % 4;
         end else if (p[2] && !sub_busy[m_idx]) begin
            m_act = 1'b0;
         end
      end
      cyc++;
   endtask

   function automatic logic [16:0] model_out();
      logic [3:0] ms;
      ms = 4'b0001 << m_idx;
      if (m_act) return {ms, 1'b1, ms, 8'h00};
      return {ms, 1'b0, 4'b0000, dig_tab[m_idx]};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en)
            chk("model", {15'd0, mode_sel, mode_entered, grant, menu_digit},
                {15'd0, model_out()});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: confirm = v;
         1: select = v;
         default: exit_b = v;
      endcase
   endtask

   task automatic press(input int b, input int hold);
      set_btn(b, 1'b1);
      cycles(hold);
      set_btn(b, 1'b0);
      cycles(12);
   endtask

   logic [3:0] rot_ms [4];
   logic [7:0] rot_dg [4];

   initial begin
      rot_ms[0] = 4'b0010; rot_dg[0] = 8'hDA;
      rot_ms[1] = 4'b0100; rot_dg[1] = 8'hF2;
      rot_ms[2] = 4'b1000; rot_dg[2] = 8'h66;
      rot_ms[3] = 4'b0001; rot_dg[3] = 8'h60;

      reset = 1'b1;
      @(posedge clk);
      chk_en = 1'b1;
      cycles(3);
      chk("rst_sel", 32'(mode_sel), 32'h1);
      chk("rst_dig", 32'(menu_digit), 32'h60);
      chk("rst_ent", 32'(mode_entered), 32'h0);
      chk("rst_gnt", 32'(grant), 32'h0);
      reset = 1'b0;
      cycles(2);

      for (int i = 0; i < 4; i++) begin
         press(1, 6);
         chk("rot_sel", 32'(mode_sel), 32'(rot_ms[i]));
         chk("rot_dig", 32'(menu_digit), 32'(rot_dg[i]));
      end

      press(1, 2);
      chk("glitch", 32'(mode_sel), 32'h1);

      select = 1'b1;
      cycles(100);
      select = 1'b0;
      cycles(12);
      chk("hold_once", 32'(mode_sel), 32'h2);

      press(2, 6);
      chk("menu_ext", 32'({mode_entered, mode_sel}), 32'h02);

      confirm = 1'b1;
      select = 1'b1;
      cycles(6);
      confirm = 1'b0;
      select = 1'b0;
      cycles(12);
      chk("cfm_ent", 32'(mode_entered), 32'h1);
      chk("cfm_gnt", 32'(grant), 32'h2);
      chk("cfm_sel", 32'(mode_sel), 32'h2);
      chk("cfm_dig", 32'(menu_digit), 32'h00);

      press(1, 6);
      press(0, 6);
      chk("act_ign", 32'({mode_entered, mode_sel}), 32'h12);

      press(2, 6);
      chk("ext_free", 32'(mode_entered), 32'h0);
      press(1, 6);
      press(0, 6);
      chk("act3_gnt", 32'(grant), 32'h4);

      sub_busy = 4'b0100;
      press(2, 6);
      chk("ext_busy", 32'(mode_entered), 32'h1);
      sub_busy = 4'b0000;
      press(2, 6);
      chk("ext_ok", 32'(mode_entered), 32'h0);
      chk("ext_gnt", 32'(grant), 32'h0);

      press(0, 6);
      sub_busy = 4'b1011;
      press(2, 6);
      chk("ext_other", 32'(mode_entered), 32'h0);

      press(0, 6);
      sub_busy = 4'b1111;
      chk("pre_rst", 32'(grant), 32'h4);
      confirm = 1'b1;
      reset = 1'b1;
      cycles(2);
      chk("rst_act", 32'({mode_entered, grant, mode_sel}), 32'h001);
      reset = 1'b0;
      cycles(7);
      chk("held_wait", 32'(mode_entered), 32'h0);
      cycles(1);
      chk("held_pulse", 32'({mode_entered, grant}), 32'h11);
      confirm = 1'b0;
      cycles(12);
      sub_busy = 4'b0000;

      force_flag = 1'b1;
      #1 force dut.mode_sel_q = 4'b0110;
      #1 release dut.mode_sel_q;
      @(negedge clk);
      chk("seu_sel", 32'(mode_sel), 32'h1);
      chk("seu_ent", 32'(mode_entered), 32'h0);
      chk("seu_dig", 32'(menu_digit), 32'h60);
      cycles(3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mode_arbiter.md
MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable clk cycles a button must hold before it is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  Single system clock; all logic is on the rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 confirm  input  1  Raw, asynchronous enter-mode button.
REQ-005 select  input  1  Raw, asynchronous next-mode button.
REQ-006 exit  input  1  Raw, asynchronous leave-mode button.
REQ-007 sub_busy  input  4  Per-mode busy flag from each sub-module, where bit i belongs to mode_sel bit i.
REQ-008 mode_sel  output  4  One-hot current mode: 0001, 0010, 0100 or 1000.
REQ-009 mode_entered  output  1  High while a mode owns the display.
REQ-010 grant  output  4  One-hot display/LED ownership; all zeros while in the menu.
REQ-011 menu_digit  output  8  Seven-segment code for the menu digit, bit order a..g,dp from MSB, active-high.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a stability counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 Each debounced rising edge SHALL produce exactly one 1-cycle pulse (cfm_p, sel_p, ext_p); holding a button produces no repeat pulse, and a glitch shorter than DEBOUNCE_CYCLES produces no pulse.
REQ-014 The pulse SHALL appear DEBOUNCE_CYCLES+3 cycles after the raw edge (2 synchronizer stages, counter, edge register), with a tolerance of ±1 cycle.
REQ-015 The FSM SHALL have two states, MENU and ACTIVE.
REQ-016 MENU, on cfm_p: move to ACTIVE on the next edge and take precedence over a simultaneous sel_p; mode_sel is held.
REQ-017 MENU, on sel_p alone: rotate mode_sel 0001->0010->0100->1000->0001 (wrap-around).
REQ-018 MENU, on ext_p: ignore it.
REQ-019 ACTIVE, on ext_p while (sub_busy & mode_sel)==0: move to MENU on the next edge.
REQ-020 ACTIVE, on ext_p while the owning mode is busy: drop the pulse; it is not queued, so the user must press exit again.
REQ-021 ACTIVE: sel_p and cfm_p SHALL be ignored, and mode_sel SHALL NOT change.
REQ-022 mode_entered, grant and menu_digit SHALL be registered and SHALL change on the same edge as the state change.
REQ-023 Outputs in ACTIVE: mode_entered=1, grant=mode_sel, menu_digit=0x00.
REQ-024 Outputs in MENU: mode_entered=0, grant=0000, menu_digit=0x60/0xDA/0xF2/0x66 for mode_sel 0001/0010/0100/1000.
REQ-025 A non-one-hot mode_sel (SEU or bug) SHALL be forced to 0001 on the next edge, with the state forced to MENU.
REQ-026 sub_busy bits of modes that are not selected SHALL have no effect.

Reset
REQ-027 While reset=1 at a clk edge, the block SHALL load state=MENU, mode_sel=0001, mode_entered=0, grant=0000, menu_digit=0x60.
REQ-028 Reset SHALL also clear the synchronizers, stability counters, debounced levels and pulses.
REQ-029 A button held through reset release SHALL be re-debounced from zero and produce one pulse after DEBOUNCE_CYCLES+3 cycles.
REQ-030 Reset asserted while ACTIVE SHALL return the block to MENU regardless of sub_busy.

Structure
REQ-031 Shared package mode_pkg SHALL hold the state enum {MENU, ACTIVE}, the one-hot constants MODE1..MODE4 and the seven-segment constants NUM0..NUM4.
REQ-032 One sub-module, btn_debounce (synchronizer + counter + edge pulse, parameterized by DEBOUNCE_CYCLES), SHALL be instantiated three times.
REQ-033 The top-level RTL SHALL contain the FSM and output registers only.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Reset, then 3 clean select presses -> mode_sel 0010, 0100, 1000 and menu_digit 0xDA, 0xF2, 0x66; a 4th press -> 0001 and 0x60.
REQ-035 A 2-cycle select glitch -> no pulse and mode_sel unchanged; select held 100 cycles -> exactly one rotation.
REQ-036 confirm and select released to pulse on the same cycle in MENU with mode 0010 -> ACTIVE, grant=0010, mode_sel=0010, menu_digit=0x00.
REQ-037 ACTIVE mode 0100 with sub_busy=0100, press exit -> stays ACTIVE; clear sub_busy, press exit -> MENU, grant=0000; sub_busy=1011 -> exit accepted.
REQ-038 Reset pulsed while ACTIVE with sub_busy=1111 -> MENU, mode_sel=0001, grant=0000; confirm held across reset -> one pulse 7 cycles after release.
REQ-039 Force mode_sel=0110 via testbench -> next cycle mode_sel=0001, state=MENU.
